alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Multicycle control FSM that sequences the 32-bit ALU for one instruction at a time.
//  Accepts a 5-bit opcode over a valid/ready handshake and drives ALUControl for the ALU.
//  Issues memory, register-file and PC strobes in order, and raises traps for illegal
//  opcodes and memory timeouts. Sits between the instruction front end and the ALU/memory path.
// PARAMETERS
//  MULDIV_CYCLES  4   EXECUTE dwell cycles for MUL(01000)/DIV(01001); must be >=1
//  MEM_TIMEOUT    15  cycles mem_read/mem_write may wait for mem_ack before trap; must be >=1
// PORTS
//  clk           in   1  rising-edge clock
//  reset         in   1  synchronous, active-high reset
//  instr_valid   in   1  opcode valid from front end
//  instr_ready   out  1  sequencer can accept an opcode
//  opcode        in   5  ALU op encoding (00000..10101 legal; 10110..11111 illegal)
//  alu_zero      in   1  ALU zero/branch-taken output
//  mem_ack       in   1  memory completion, single-cycle pulse
//  alu_control   out  5  ALUControl to the ALU
//  reg_write     out  1  register-file write strobe
//  mem_read      out  1  memory read request, level-held until ack
//  mem_write     out  1  memory write request, level-held until ack
//  pc_write      out  1  load PC from BranchTarget
//  retire        out  1  one-cycle pulse in the last cycle of a completed instruction
//  trap          out  1  one-cycle pulse in the TRAP state
//  trap_cause    out  2  01 = illegal opcode, 10 = memory timeout; held until the next trap
//  busy          out  1  state != IDLE
// BEHAVIOUR
//  - States: IDLE=0, DECODE=1, EXECUTE=2, MEM_RD=3, MEM_WR=4, WRITEBACK=5, BRANCH=6, TRAP=7.
//  - Outputs are Moore-decoded from the state register and the latched op_q.
//    Exception: instr_ready = (state==IDLE) & ~reset.
//  - Reset (sampled at a clk edge): state=IDLE, op_q=NOP(10101), counters=0, zero_q=0,
//    trap_cause=00. Outputs are then alu_control=10101 and all strobes/busy/trap=0.
//    A reset mid-instruction aborts it at that edge; no strobe occurs after the edge.
//  - Accept: instr_valid & instr_ready at edge T0 latches op_q and sets state to DECODE.
//    instr_valid is ignored in every other state.
//  - alu_control = op_q in DECODE through BRANCH; 10101 in IDLE and TRAP.
//  - DECODE (1 cycle): op_q>10101 -> TRAP with trap_cause=01. Otherwise -> EXECUTE.
//  - EXECUTE: 1 cycle, or MULDIV_CYCLES cycles for MUL/DIV (dwell counter).
//    zero_q <= alu_zero on the last EXECUTE cycle.
//    Next state by op_q:
//      LW_1/2/3           -> MEM_RD
//      SW_1/2             -> MEM_WR
//      MOV..NOT except CMP -> WRITEBACK
//      JR/JPC/BRFL/CALL/RET -> BRANCH
//      CMP, NOP           -> IDLE with retire=1 in that EXECUTE cycle.
//  - MEM_RD/MEM_WR: request held high. A wait counter starts at 0 on entry and increments
//    each cycle without ack.
//      mem_ack -> MEM_RD goes to WRITEBACK; MEM_WR goes to IDLE with retire=1 in that cycle.
//      Wait counter == MEM_TIMEOUT-1 and no ack -> TRAP with trap_cause=10.
//      If ack arrives in that same cycle, the ack wins.
//  - WRITEBACK (1 cycle): reg_write=1, retire=1 -> IDLE.
//  - BRANCH (1 cycle): pc_write=zero_q; reg_write=1 only for CALL (link = PC+1); retire=1 -> IDLE.
//    BRFL with zero_q=0 retires without pc_write.
//  - TRAP (1 cycle): trap=1, no retire -> IDLE.
//  - Minimum latency from accept edge to the next instr_ready:
//      ALU op 4 cycles; NOP/CMP 3; branch 4; LW with same-cycle ack 5.
//  - mem_ack outside MEM_RD/MEM_WR is ignored.
// TESTING
//  1. Reset 2 cycles, release -> instr_ready=1 and alu_control=10101 the first cycle reset is low.
//     Offer ADD(00110) -> DECODE, EXECUTE, WRITEBACK: reg_write and retire high exactly 1 cycle
//     at T3; instr_ready=1 at T4.
//  2. MUL(01000), MULDIV_CYCLES=4 -> alu_control=01000 for 5 cycles (DECODE+4 EXECUTE);
//     reg_write at T6.
//  3. LW_1(00000), mem_ack 3 cycles after MEM_RD entry -> mem_read high 4 cycles, then reg_write 1 cycle.
//     SW_1 with no ack -> mem_write high 15 cycles, trap=1, trap_cause=10, reg_write never asserted.
//  4. Opcode 11000 -> trap pulse at T2, trap_cause=01, no retire.
//     JR with alu_zero=1 -> pc_write at T3.
//     BRFL with alu_zero=0 -> pc_write=0, retire=1.
//     CALL -> pc_write=1 and reg_write=1 together.
//  5. Reset during MEM_RD -> mem_read low after the reset edge; no reg_write; instr_ready high
//     after release. mem_ack pulsed in IDLE -> no effect.
//  6. Back-to-back: instr_valid held high with CMP then NOP -> second accept on the edge where
//     instr_ready=1; each retires once.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer_if
//  Description : Handshake and control bundle between the instruction front
//                end (master) and the ALU operation sequencer (slave).
//  Signals     : instr_valid/instr_ready/opcode  - opcode handshake
//                alu_zero, mem_ack               - status back from ALU/memory
//                alu_control, reg_write, mem_read, mem_write, pc_write,
//                retire, trap, trap_cause, busy  - sequencer outputs
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_op_sequencer_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [4:0] opcode;
  logic       alu_zero;
  logic       mem_ack;
  logic [4:0] alu_control;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       pc_write;
  logic       retire;
  logic       trap;
  logic [1:0] trap_cause;
  logic       busy;

  // Front end / environment side.
  modport master (
    output instr_valid, opcode, alu_zero, mem_ack,
    input  instr_ready, alu_control, reg_write, mem_read, mem_write,
           pc_write, retire, trap, trap_cause, busy
  );

  // Sequencer side.
  modport slave (
    input  instr_valid, opcode, alu_zero, mem_ack,
    output instr_ready, alu_control, reg_write, mem_read, mem_write,
           pc_write, retire, trap, trap_cause, busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Multicycle control FSM sequencing the 32-bit ALU for one
//                instruction at a time. Accepts an opcode over valid/ready,
//                drives ALUControl, issues memory/register-file/PC strobes
//                and raises traps for illegal opcodes and memory timeouts.
//  Ports       : clk   - rising-edge clock
//                reset - synchronous active-high reset
//                bus   - alu_op_sequencer_if.slave (handshake, status, strobes)
//  Opcode map  : 00000-00010 LW_1..3   00011-00100 SW_1..2
//                00101 MOV 00110 ADD 00111 SUB 01000 MUL 01001 DIV
//                01010 AND 01011 OR  01100 XOR 01101 SHL 01110 CMP 01111 NOT
//                10000 JR  10001 JPC 10010 BRFL 10011 CALL 10100 RET
//                10101 NOP           10110-11111 illegal
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
  parameter int MULDIV_CYCLES = 4,
  parameter int MEM_TIMEOUT   = 15
) (
  input  wire logic         clk,
  input  wire logic         reset,
  alu_op_sequencer_if.slave bus
);

  localparam logic [4:0] OP_LW_3 = 5'b00010;
  localparam logic [4:0] OP_SW_2 = 5'b00100;
  localparam logic [4:0] OP_MUL  = 5'b01000;
  localparam logic [4:0] OP_DIV  = 5'b01001;
  localparam logic [4:0] OP_CMP  = 5'b01110;
  localparam logic [4:0] OP_NOT  = 5'b01111;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_NOP  = 5'b10101;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_MEM_TMO = 2'b10;

  // One counter serves both the MUL/DIV dwell and the memory wait, since the
  // two phases never overlap.
  localparam int CNT_MAX = (MULDIV_CYCLES > MEM_TIMEOUT) ? MULDIV_CYCLES : MEM_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MULDIV_LAST = CNT_W'(MULDIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] MEM_LAST    = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM_RD    = 3'd3,
    S_MEM_WR    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_BRANCH    = 3'd6,
    S_TRAP      = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic [1:0]       cause_q, cause_d;

  logic [4:0] alu_control;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       pc_write;
  logic       retire;
  logic       trap;
  logic       exec_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    zero_d      = zero_q;
    cause_d     = cause_q;
    alu_control = OP_NOP;
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    pc_write    = 1'b0;
    retire      = 1'b0;
    trap        = 1'b0;
    // MUL/DIV dwell in EXECUTE; every other op spends a single cycle there.
    exec_last   = !((op_q == OP_MUL) || (op_q == OP_DIV)) || (cnt_q == MULDIV_LAST);

    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          op_d    = bus.opcode;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        alu_control = op_q;
        cnt_d       = '0;
        if (op_q > OP_NOP) begin
          cause_d = CAUSE_ILLEGAL;
          state_d = S_TRAP;
        end else begin
          state_d = S_EXECUTE;
        end
      end

      S_EXECUTE: begin
        alu_control = op_q;
        if (exec_last) begin
          zero_d = bus.alu_zero;
          cnt_d  = '0;
          // Opcode groups are contiguous, so ordered range tests classify them.
          if (op_q <= OP_LW_3) begin
            state_d = S_MEM_RD;
          end else if (op_q <= OP_SW_2) begin
            state_d = S_MEM_WR;
          end else if ((op_q == OP_CMP) || (op_q == OP_NOP)) begin
            retire  = 1'b1;
            state_d = S_IDLE;
          end else if (op_q <= OP_NOT) begin
            state_d = S_WRITEBACK;
          end else begin
            state_d = S_BRANCH;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_MEM_RD, S_MEM_WR: begin
        alu_control = op_q;
        mem_read    = (state_q == S_MEM_RD);
        mem_write   = (state_q == S_MEM_WR);
        // An ack in the final wait cycle still completes the access.
        if (bus.mem_ack) begin
          cnt_d = '0;
          if (state_q == S_MEM_RD) begin
            state_d = S_WRITEBACK;
          end else begin
            retire  = 1'b1;
            state_d = S_IDLE;
          end
        end else if (cnt_q == MEM_LAST) begin
          cnt_d   = '0;
          cause_d = CAUSE_MEM_TMO;
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_WRITEBACK: begin
        alu_control = op_q;
        reg_write   = 1'b1;
        retire      = 1'b1;
        state_d     = S_IDLE;
      end

      S_BRANCH: begin
        alu_control = op_q;
        pc_write    = zero_q;
        reg_write   = (op_q == OP_CALL);  // link register write for CALL
        retire      = 1'b1;
        state_d     = S_IDLE;
      end

      S_TRAP: begin
        trap    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.instr_ready = (state_q == S_IDLE) && !reset;
  assign bus.alu_control = alu_control;
  assign bus.reg_write   = reg_write;
  assign bus.mem_read    = mem_read;
  assign bus.mem_write   = mem_write;
  assign bus.pc_write    = pc_write;
  assign bus.retire      = retire;
  assign bus.trap        = trap;
  assign bus.trap_cause  = cause_q;
  assign bus.busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_sequencer
//  Description : Self-checking bench for alu_op_sequencer. A reference model
//                expands each instruction into its expected per-cycle output
//                trace, which is compared cycle by cycle against the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

  localparam int MULDIV = 4;
  localparam int TMO    = 15;
  localparam logic [4:0] NOP = 5'b10101;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   exp_cause;

  logic [11:0] exp_q[$];
  bit          ack_q[$];

  alu_op_sequencer_if bus ();

  alu_op_sequencer #(.MULDIV_CYCLES(MULDIV), .MEM_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {alu_control, reg_write, mem_read, mem_write, pc_write, retire, trap, busy}
  logic [11:0] obs;
  assign obs = {bus.alu_control, bus.reg_write, bus.mem_read, bus.mem_write,
                bus.pc_write, bus.retire, bus.trap, bus.busy};

  function automatic logic [11:0] vec(input logic [4:0] a, input bit rw, input bit mr,
                                      input bit mw, input bit pw, input bit rt,
                                      input bit tp, input bit bz);
    return {a, rw, mr, mw, pw, rt, tp, bz};
  endfunction

  // Reference model: per-cycle outputs from the accept edge until back in IDLE.
  // ad = wait index of mem_ack in a memory phase (out of range = never acked).
  task automatic build(input logic [4:0] op, input bit z, input int ad);
    int n;
    bit rd;
    bit acked;
    exp_q.delete();
    ack_q.delete();
    exp_q.push_back(vec(op, 0, 0, 0, 0, 0, 0, 1));
    ack_q.push_back(1'($urandom_range(0, 1)));
    if (op > 5'd21) begin
      exp_q.push_back(vec(NOP, 0, 0, 0, 0, 0, 1, 1));
      ack_q.push_back(1'($urandom_range(0, 1)));
      exp_cause = 1;
      return;
    end
    n = (op == 5'd8 || op == 5'd9) ? MULDIV : 1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(vec(op, 0, 0, 0, 0, (i == n - 1) && (op == 5'd14 || op == 5'd21), 0, 1));
      ack_q.push_back(1'($urandom_range(0, 1)));
    end
    if (op <= 5'd4) begin
      rd    = (op <= 5'd2);
      acked = 1'b0;
      for (int w = 0; w < TMO; w++) begin
        acked = (w == ad);
        exp_q.push_back(vec(op, 0, rd, !rd, 0, !rd && acked, 0, 1));
        ack_q.push_back(acked);
        if (acked) break;
      end
      if (!acked) begin
        exp_q.push_back(vec(NOP, 0, 0, 0, 0, 0, 1, 1));
        ack_q.push_back(1'($urandom_range(0, 1)));
        exp_cause = 2;
      end else if (rd) begin
        exp_q.push_back(vec(op, 1, 0, 0, 0, 1, 0, 1));
        ack_q.push_back(1'($urandom_range(0, 1)));
      end
    end else if (op <= 5'd15 && op != 5'd14) begin
      exp_q.push_back(vec(op, 1, 0, 0, 0, 1, 0, 1));
      ack_q.push_back(1'($urandom_range(0, 1)));
    end else if (op >= 5'd16 && op <= 5'd20) begin
      exp_q.push_back(vec(op, op == 5'd19, 0, 0, z, 1, 0, 1));
      ack_q.push_back(1'($urandom_range(0, 1)));
    end
  endtask

  // Entered and left 4 time units into an IDLE cycle.
  task automatic run_instr(input logic [4:0] op, input bit z, input int ad, input string name);
    build(op, z, ad);
    bus.opcode      = op;
    bus.instr_valid = 1'b1;
    bus.alu_zero    = z;
    bus.mem_ack     = 1'b0;
    #2;
    n_checks++;
    if (bus.instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s accept: instr_ready=%b expected 1", name, bus.instr_ready);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #2;
      bus.instr_valid = 1'($urandom_range(0, 1));
      bus.opcode      = 5'($urandom);
      bus.mem_ack     = ack_q[i];
      #2;
      n_checks++;
      if (obs !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s cycle T%0d: outputs=%h expected %h", name, i + 1, obs, exp_q[i]);
      end
    end
    @(posedge clk); #2;
    bus.instr_valid = 1'b0;
    bus.mem_ack     = 1'b0;
    #2;
    n_checks++;
    if (obs !== vec(NOP, 0, 0, 0, 0, 0, 0, 0) || bus.instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s return to idle: outputs=%h ready=%b expected %h ready=1",
               name, obs, bus.instr_ready, vec(NOP, 0, 0, 0, 0, 0, 0, 0));
    end
    n_checks++;
    if (bus.trap_cause !== 2'(exp_cause)) begin
      n_fail++;
      $display("FAIL %s trap_cause: got %b expected %0d", name, bus.trap_cause, exp_cause);
    end
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    bus.instr_valid = 1'b1;
    bus.opcode      = 5'b00110;
    bus.alu_zero    = 1'b0;
    bus.mem_ack     = 1'b0;
    repeat (2) @(posedge clk);
    #4;
    n_checks++;
    if (bus.instr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset ready_in_reset: got %b expected 0", bus.instr_ready);
    end
    reset = 1'b0;
    bus.instr_valid = 1'b0;
    #1;
    n_checks++;
    if (obs !== vec(NOP, 0, 0, 0, 0, 0, 0, 0) || bus.instr_ready !== 1'b1 || bus.trap_cause !== 2'b00) begin
      n_fail++;
      $display("FAIL reset first_cycle: outputs=%h ready=%b cause=%b expected %h 1 00",
               obs, bus.instr_ready, bus.trap_cause, vec(NOP, 0, 0, 0, 0, 0, 0, 0));
    end
    @(posedge clk); #4;
    exp_cause = 0;
  endtask

  task automatic test_alu();
    run_instr(5'b00110, 1'b0, -1, "add");
    run_instr(5'b01111, 1'b1, -1, "not");
  endtask

  task automatic test_muldiv();
    run_instr(5'b01000, 1'b0, -1, "mul");
    run_instr(5'b01001, 1'b1, -1, "div");
  endtask

  task automatic test_mem();
    run_instr(5'b00000, 1'b0, 3, "lw1_ack3");
    run_instr(5'b00011, 1'b0, -1, "sw1_timeout");
    run_instr(5'b00001, 1'b0, 0, "lw2_ack0");
    run_instr(5'b00100, 1'b0, TMO - 1, "sw2_ack_last");
    run_instr(5'b00010, 1'b1, -1, "lw3_timeout");
  endtask

  task automatic test_trap_branch();
    run_instr(5'b11000, 1'b0, -1, "illegal");
    run_instr(5'b10000, 1'b1, -1, "jr_taken");
    run_instr(5'b10010, 1'b0, -1, "brfl_not_taken");
    run_instr(5'b10011, 1'b1, -1, "call");
    run_instr(5'b11111, 1'b1, -1, "illegal_max");
  endtask

  task automatic test_reset_mid();
    bus.opcode      = 5'b00000;
    bus.instr_valid = 1'b1;
    bus.mem_ack     = 1'b0;
    @(posedge clk); #2;
    bus.instr_valid = 1'b0;
    repeat (3) @(posedge clk);  // DECODE, EXECUTE, MEM_RD wait 0 -> now in wait 1
    #4;
    n_checks++;
    if (bus.mem_read !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid mem_read_before: got %b expected 1", bus.mem_read);
    end
    reset = 1'b1;
    @(posedge clk); #4;
    n_checks++;
    if (obs !== vec(NOP, 0, 0, 0, 0, 0, 0, 0) || bus.instr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid after_edge: outputs=%h ready=%b expected %h ready=0",
               obs, bus.instr_ready, vec(NOP, 0, 0, 0, 0, 0, 0, 0));
    end
    reset = 1'b0;
    exp_cause = 0;
    #1;
    n_checks++;
    if (bus.instr_ready !== 1'b1 || bus.trap_cause !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid release: ready=%b cause=%b expected 1 00", bus.instr_ready, bus.trap_cause);
    end
    @(posedge clk); #2;
    bus.mem_ack = 1'b1;
    @(posedge clk); #2;
    bus.mem_ack = 1'b0;
    #2;
    n_checks++;
    if (obs !== vec(NOP, 0, 0, 0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL idle_ack no_effect: outputs=%h expected %h", obs, vec(NOP, 0, 0, 0, 0, 0, 0, 0));
    end
    run_instr(5'b00111, 1'b0, -1, "sub_after_reset");
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_bb[6];
    int          retires;
    exp_bb[0] = vec(5'b01110, 0, 0, 0, 0, 0, 0, 1);
    exp_bb[1] = vec(5'b01110, 0, 0, 0, 0, 1, 0, 1);
    exp_bb[2] = vec(NOP, 0, 0, 0, 0, 0, 0, 0);
    exp_bb[3] = vec(NOP, 0, 0, 0, 0, 0, 0, 1);
    exp_bb[4] = vec(NOP, 0, 0, 0, 0, 1, 0, 1);
    exp_bb[5] = vec(NOP, 0, 0, 0, 0, 0, 0, 0);
    retires = 0;
    bus.opcode      = 5'b01110;
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #2;
      if (i == 0) bus.opcode = NOP;
      if (i == 3) bus.instr_valid = 1'b0;
      #2;
      retires += int'(bus.retire);
      n_checks++;
      if (obs !== exp_bb[i]) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: outputs=%h expected %h", i + 1, obs, exp_bb[i]);
      end
      if (i == 2) begin
        n_checks++;
        if (bus.instr_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL back_to_back ready: got %b expected 1", bus.instr_ready);
        end
      end
    end
    n_checks++;
    if (retires != 2) begin
      n_fail++;
      $display("FAIL back_to_back retire_count: got %0d expected 2", retires);
    end
  endtask

  task automatic test_random();
    logic [4:0] op;
    for (int k = 0; k < 40; k++) begin
      op = 5'($urandom_range(0, 31));
      run_instr(op, 1'($urandom_range(0, 1)), int'($urandom_range(0, TMO + 2)), $sformatf("rand%0d_op%b", k, op));
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_cause = 0;
    test_reset();
    test_alu();
    test_muldiv();
    test_mem();
    test_trap_branch();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
